// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Shared types and constants for the SPI flash read controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_CMD  = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4,
    ST_RESP = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         DATA_BITS = 32;

  // Flash returns byte 0 first; the CPU wants it in the low byte
  function automatic logic [31:0] bytes_le(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sck_gen
// Description : SCK generator. Each SCK phase lasts CLK_DIV clk cycles; the
//               rise/fall strobes are high in the cycle whose closing clk
//               edge flips SCK. Clear forces SCK low and restarts the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [3:0] c_cnt_last = 4'(CLK_DIV - 1);

  logic [3:0] r_cnt;
  logic       r_sck;
  logic       w_wrap;

  assign w_wrap = i_en && !i_clr && (r_cnt == c_cnt_last);
  assign o_sck  = r_sck;
  assign o_rise = w_wrap && !r_sck;
  assign o_fall = w_wrap && r_sck;

  // Phase counter and SCK level; SCK toggles at the end of each phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 4'd0;
      r_sck <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt <= 4'd0;
        r_sck <= ~r_sck;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_flash_rdctl.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_rdctl
// Description : Word-fetch SPI flash read controller. Each request becomes a
//               single-bit READ (0x03) in SPI mode 0; with CONT_EN the chip
//               stays selected after a word so a sequential fetch streams on
//               without command or address.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_rdctl
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int CSB_HIGH = 2,
  parameter bit CONT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_do,
  output logic        flash_io0_oe,
  input  logic        flash_io1_di
);

  localparam logic [5:0] c_cmd_last  = 6'(CMD_BITS - 1);
  localparam logic [5:0] c_addr_last = 6'(ADDR_BITS - 1);
  localparam logic [5:0] c_data_last = 6'(DATA_BITS - 1);
  localparam logic [7:0] c_gap_last  = 8'((CSB_HIGH > 1) ? (CSB_HIGH - 1) : 0);

  state_t      r_state;
  logic [23:2] r_addr;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_pending;
  logic        r_csb;
  logic        r_oe;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;

  logic        w_sck_en;
  logic        w_sck;
  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic [23:2] w_next_word;
  logic        w_seq;
  logic        w_unused_addr_lsb;

  assign w_sck_en    = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_accept    = req_valid && r_req_ready;
  assign w_next_word = r_addr + 22'd1;
  assign w_seq       = (req_addr[23:2] == w_next_word);
  // The word address is all that matters; byte lanes are always fetched as 0
  assign w_unused_addr_lsb = ^req_addr[1:0];

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_sck_en),
    .i_clr  (!w_sck_en),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign flash_csb    = r_csb;
  assign flash_clk    = w_sck;
  assign flash_io0_do = r_tx[31];
  assign flash_io0_oe = r_oe;

  // Transaction sequencer: command/address shift-out, data shift-in, response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_GAP;
      r_addr      <= 22'd0;
      r_tx        <= 32'd0;
      r_rx        <= 32'd0;
      r_bit_cnt   <= 6'd0;
      r_gap_cnt   <= 8'd0;
      r_pending   <= 1'b0;
      r_csb       <= 1'b1;
      r_oe        <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr[23:2];
            r_tx        <= {CMD_READ, req_addr[23:2], 2'b00};
            r_csb       <= 1'b0;
            r_oe        <= 1'b1;
            r_req_ready <= 1'b0;
            r_bit_cnt   <= 6'd0;
            r_state     <= ST_CMD;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_gap_cnt <= 8'd0;
            if (r_pending) begin
              // Request was taken while streaming; start it without idling
              r_pending <= 1'b0;
              r_tx      <= {CMD_READ, r_addr, 2'b00};
              r_csb     <= 1'b0;
              r_oe      <= 1'b1;
              r_bit_cnt <= 6'd0;
              r_state   <= ST_CMD;
            end else begin
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        ST_CMD: begin
          if (w_fall) begin
            r_tx <= {r_tx[30:0], 1'b0};
            if (r_bit_cnt == c_cmd_last) begin
              r_bit_cnt <= 6'd0;
              r_state   <= ST_ADDR;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        ST_ADDR: begin
          if (w_fall) begin
            r_tx <= {r_tx[30:0], 1'b0};
            if (r_bit_cnt == c_addr_last) begin
              // Release MOSI once the last address bit has been clocked
              r_bit_cnt <= 6'd0;
              r_oe      <= 1'b0;
              r_state   <= ST_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_rise) begin
            r_rx <= {r_rx[30:0], flash_io1_di};
          end
          if (w_fall) begin
            if (r_bit_cnt == c_data_last) begin
              r_bit_cnt <= 6'd0;
              r_state   <= ST_RESP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= bytes_le(r_rx);
          if (CONT_EN) begin
            r_req_ready <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_csb     <= 1'b1;
            r_gap_cnt <= 8'd0;
            r_state   <= ST_GAP;
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_addr      <= req_addr[23:2];
            r_req_ready <= 1'b0;
            if (w_seq) begin
              // Flash is already positioned at the next word: just clock it
              r_bit_cnt <= 6'd0;
              r_state   <= ST_DATA;
            end else begin
              r_csb     <= 1'b1;
              r_pending <= 1'b1;
              r_gap_cnt <= 8'd0;
              r_state   <= ST_GAP;
            end
          end
        end
        default: begin
          r_csb       <= 1'b1;
          r_oe        <= 1'b0;
          r_req_ready <= 1'b0;
          r_gap_cnt   <= 8'd0;
          r_state     <= ST_GAP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
